// File: rtl/sprite_plot_stage.sv
// sprite_plot_stage: sequences one sprite draw, aligns drawer coordinates with
// the sprite ROM colour, clips to the screen and drives the VGA adapter.
// Optional build macro SPRITE_TRANSPARENCY_EN: suppress plot for pixels whose
// colour equals TRANSPARENT_COLOUR.
module sprite_plot_stage #(
  parameter int unsigned ROM_LATENCY        = 1,
  parameter int unsigned SCREEN_W           = 320,
  parameter int unsigned SCREEN_H           = 240,
  parameter logic [2:0]  TRANSPARENT_COLOUR = 3'b000
) (
  input  logic       clock_all,
  input  logic       reset_all,
  input  logic       start,
  output logic       busy,
  output logic       finished,
  output logic       draw_enable,
  output logic       draw_reset_n,
  input  logic [8:0] src_x,
  input  logic [7:0] src_y,
  input  logic [2:0] src_colour,
  input  logic       src_done,
  output logic       plot,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour
);

  localparam int unsigned XW    = 9;
  localparam int unsigned YW    = 8;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned TAIL  = ROM_LATENCY - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_DRAW,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  flush_cnt;

  logic [XW-1:0]     dl_x [ROM_LATENCY];
  logic [YW-1:0]     dl_y [ROM_LATENCY];
  logic              dl_v [ROM_LATENCY];

  logic              push_valid_c;
  logic [XW-1:0]     tail_x_c;
  logic [YW-1:0]     tail_y_c;
  logic              tail_v_c;
  logic              on_screen_c;
  logic              opaque_c;
  logic              plot_c;

  // Only coordinates taken while the drawer is running carry a valid flag
  assign push_valid_c = (state == S_DRAW);

  assign tail_x_c = dl_x[TAIL];
  assign tail_y_c = dl_y[TAIL];
  assign tail_v_c = dl_v[TAIL];

  // Unsigned clip on the full coordinate widths
  assign on_screen_c = (32'(tail_x_c) < SCREEN_W) && (32'(tail_y_c) < SCREEN_H);

`ifdef SPRITE_TRANSPARENCY_EN
  assign opaque_c = (src_colour != TRANSPARENT_COLOUR);
`else
  assign opaque_c = 1'b1;
`endif

  assign plot_c = tail_v_c && on_screen_c && opaque_c;

  // Sequencer: IDLE -> ARM -> DRAW -> FLUSH -> DONE, with registered controls
  always_ff @(posedge clock_all or negedge reset_all) begin
    if (!reset_all) begin
      state        <= S_IDLE;
      flush_cnt    <= '0;
      busy         <= 1'b0;
      finished     <= 1'b0;
      draw_enable  <= 1'b0;
      draw_reset_n <= 1'b0;
    end else begin
      finished <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_ARM;
            busy         <= 1'b1;
            draw_reset_n <= 1'b1;
            draw_enable  <= 1'b0;
          end
        end
        S_ARM: begin
          state       <= S_DRAW;
          draw_enable <= 1'b1;
        end
        S_DRAW: begin
          if (src_done) begin
            state       <= S_FLUSH;
            draw_enable <= 1'b0;
            flush_cnt   <= '0;
          end
        end
        S_FLUSH: begin
          if (flush_cnt == CNT_W'(ROM_LATENCY - 1)) begin
            state        <= S_DONE;
            finished     <= 1'b1;
            draw_reset_n <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state        <= S_IDLE;
          busy         <= 1'b0;
          draw_enable  <= 1'b0;
          draw_reset_n <= 1'b0;
        end
      endcase
    end
  end

  // Coordinate delay line matching the ROM read latency
  always_ff @(posedge clock_all or negedge reset_all) begin
    if (!reset_all) begin
      for (int i = 0; i < int'(ROM_LATENCY); i++) begin
        dl_x[i] <= '0;
        dl_y[i] <= '0;
        dl_v[i] <= 1'b0;
      end
    end else begin
      dl_x[0] <= src_x;
      dl_y[0] <= src_y;
      dl_v[0] <= push_valid_c;
      for (int i = 1; i < int'(ROM_LATENCY); i++) begin
        dl_x[i] <= dl_x[i-1];
        dl_y[i] <= dl_y[i-1];
        dl_v[i] <= dl_v[i-1];
      end
    end
  end

  // Adapter output register; pixel fields follow every valid tail entry
  always_ff @(posedge clock_all or negedge reset_all) begin
    if (!reset_all) begin
      plot       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      plot <= plot_c;
      if (tail_v_c) begin
        vga_x      <= tail_x_c;
        vga_y      <= tail_y_c;
        vga_colour <= src_colour;
      end
    end
  end

endmodule

// File: tb/tb_sprite_plot_stage.sv
// Scoreboard bench for sprite_plot_stage: a 2x2 drawer/ROM model feeds two
// instances (ROM latency 1 and 3); expected pixels are queued per test.
module tb_sprite_plot_stage;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- instance with ROM_LATENCY = 1 ----------------
  logic       start1 = 1'b0;
  logic       busy1, fin1, en1, drn1, plot1, sd1;
  logic [8:0] sx1, vx1;
  logic [7:0] sy1, vy1;
  logic [2:0] sc1, vc1;
  logic [8:0] x0_1 = '0;
  logic [7:0] y0_1 = '0;
  logic [2:0] rom1 [4];
  logic [1:0] k1 = '0, kh1 = '0;

  always @(posedge clk) begin
    if (!drn1) k1 <= 2'd0;
    else if (en1) k1 <= k1 + 2'd1;
    kh1 <= k1;
  end
  assign sx1 = x0_1 + 9'(k1[0]);
  assign sy1 = y0_1 + 8'(k1[1]);
  assign sd1 = (k1 == 2'd3);
  assign sc1 = rom1[kh1];

  sprite_plot_stage #(.ROM_LATENCY(1)) dut1 (
    .clock_all(clk), .reset_all(rst_n), .start(start1),
    .busy(busy1), .finished(fin1), .draw_enable(en1), .draw_reset_n(drn1),
    .src_x(sx1), .src_y(sy1), .src_colour(sc1), .src_done(sd1),
    .plot(plot1), .vga_x(vx1), .vga_y(vy1), .vga_colour(vc1)
  );

  // ---------------- instance with ROM_LATENCY = 3 ----------------
  logic       start3 = 1'b0;
  logic       busy3, fin3, en3, drn3, plot3, sd3;
  logic [8:0] sx3, vx3;
  logic [7:0] sy3, vy3;
  logic [2:0] sc3, vc3;
  logic [8:0] x0_3 = '0;
  logic [7:0] y0_3 = '0;
  logic [2:0] rom3 [4];
  logic [1:0] k3 = '0, kh3a = '0, kh3b = '0, kh3c = '0;

  always @(posedge clk) begin
    if (!drn3) k3 <= 2'd0;
    else if (en3) k3 <= k3 + 2'd1;
    kh3a <= k3;
    kh3b <= kh3a;
    kh3c <= kh3b;
  end
  assign sx3 = x0_3 + 9'(k3[0]);
  assign sy3 = y0_3 + 8'(k3[1]);
  assign sd3 = (k3 == 2'd3);
  assign sc3 = rom3[kh3c];

  sprite_plot_stage #(.ROM_LATENCY(3)) dut3 (
    .clock_all(clk), .reset_all(rst_n), .start(start3),
    .busy(busy3), .finished(fin3), .draw_enable(en3), .draw_reset_n(drn3),
    .src_x(sx3), .src_y(sy3), .src_colour(sc3), .src_done(sd3),
    .plot(plot3), .vga_x(vx3), .vga_y(vy3), .vga_colour(vc3)
  );

  // ---------------- scoreboard ----------------
  pix_t q1[$];
  pix_t q3[$];
  int pc1 = 0, fc1 = 0, first1 = -1, fcyc1 = -1;
  int pc3 = 0, fc3 = 0, first3 = -1, fcyc3 = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor for the latency-1 instance
  always @(negedge clk) begin
    pix_t e;
    if (plot1) begin
      if (pc1 == 0) first1 = cyc;
      pc1++;
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL plot1_unexpected: got (%0d,%0d,%0d) expected no plot", vx1, vy1, vc1);
      end else begin
        e = q1.pop_front();
        chk("plot1_pixel", 32'({vx1, vy1, vc1}), 32'(e));
      end
    end
    if (fin1) begin
      fc1++;
      fcyc1 = cyc;
    end
  end

  // Monitor for the latency-3 instance
  always @(negedge clk) begin
    pix_t e;
    if (plot3) begin
      if (pc3 == 0) first3 = cyc;
      pc3++;
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL plot3_unexpected: got (%0d,%0d,%0d) expected no plot", vx3, vy3, vc3);
      end else begin
        e = q3.pop_front();
        chk("plot3_pixel", 32'({vx3, vy3, vc3}), 32'(e));
      end
    end
    if (fin3) begin
      fc3++;
      fcyc3 = cyc;
    end
  end

  task automatic exp1(input int x, input int y, input int c);
    pix_t p;
    p.x = 9'(x); p.y = 8'(y); p.c = 3'(c);
    q1.push_back(p);
  endtask

  task automatic exp3(input int x, input int y, input int c);
    pix_t p;
    p.x = 9'(x); p.y = 8'(y); p.c = 3'(c);
    q3.push_back(p);
  endtask

  task automatic sprite1(input int x, input int y, input int c0, input int c1,
                         input int c2, input int c3);
    x0_1 = 9'(x); y0_1 = 8'(y);
    rom1[0] = 3'(c0); rom1[1] = 3'(c1); rom1[2] = 3'(c2); rom1[3] = 3'(c3);
  endtask

  // One draw: start pulse, optional second start, timing and count checks
  task automatic run(input bit which, input int restart_at, input int exp_plots, input int lat);
    int s;
    int n;
    bit busy_ok;
    if (!which) begin pc1 = 0; fc1 = 0; first1 = -1; fcyc1 = -1; end
    else begin pc3 = 0; fc3 = 0; first3 = -1; fcyc3 = -1; end
    @(negedge clk);
    s = cyc;
    if (!which) start1 = 1'b1; else start3 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
    #1;
    chk("busy_after_start", 32'(which ? busy3 : busy1), 1);
    chk("arm_draw_reset_n", 32'(which ? drn3 : drn1), 1);
    chk("arm_draw_enable", 32'(which ? en3 : en1), 0);
    busy_ok = 1'b1;
    n = 0;
    while (((which ? fc3 : fc1) == 0) && n < 40) begin
      @(negedge clk);
      #1;
      n++;
      if (!which) start1 = (restart_at != 0) && (cyc == s + restart_at);
      if (!(which ? busy3 : busy1)) busy_ok = 1'b0;
    end
    start1 = 1'b0;
    chk("busy_held_until_done", 32'(busy_ok), 1);
    chk("finished_cycle", 32'((which ? fcyc3 : fcyc1) - s), 32'(6 + lat));
    @(negedge clk);
    #1;
    chk("busy_after_done", 32'(which ? busy3 : busy1), 0);
    chk("finished_one_cycle", 32'(which ? fin3 : fin1), 0);
    repeat (4) @(negedge clk);
    #1;
    chk("plot_count", 32'(which ? pc3 : pc1), 32'(exp_plots));
    chk("finished_count", 32'(which ? fc3 : fc1), 1);
    chk("queue_drained", 32'(which ? q3.size() : q1.size()), 0);
    if (exp_plots > 0)
      chk("first_plot_cycle", 32'((which ? first3 : first1) - s), 32'(3 + lat));
  endtask

  initial begin
    int n;
    int exp_t;
    sprite1(10, 20, 1, 2, 3, 4);
    x0_3 = 9'd10; y0_3 = 8'd20;
    rom3[0] = 3'd5; rom3[1] = 3'd6; rom3[2] = 3'd7; rom3[3] = 3'd1;

    // Reset state, with start held during reset
    rst_n = 1'b0;
    start1 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_plot", 32'(plot1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_finished", 32'(fin1), 0);
    chk("rst_draw_enable", 32'(en1), 0);
    chk("rst_draw_reset_n", 32'(drn1), 0);
    chk("rst_vga", 32'({vx1, vy1, vc1}), 0);
    start1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_after_reset_busy", 32'(busy1), 0);

    // Basic 2x2 draw at (10,20)
    sprite1(10, 20, 1, 2, 3, 4);
    exp1(10, 20, 1); exp1(11, 20, 2); exp1(10, 21, 3); exp1(11, 21, 4);
    run(1'b0, 0, 4, 1);
    chk("basic_vga_hold", 32'({vx1, vy1, vc1}), 32'({9'd11, 8'd21, 3'd4}));

    // Right-edge clip: x=320 column dropped, but vga_* still follow it
    sprite1(319, 20, 5, 6, 7, 1);
    exp1(319, 20, 5); exp1(319, 21, 7);
    run(1'b0, 0, 2, 1);
    chk("clipx_vga_hold", 32'({vx1, vy1, vc1}), 32'({9'd320, 8'd21, 3'd1}));

    // Bottom-edge clip: y=240 row dropped
    sprite1(10, 239, 2, 3, 4, 5);
    exp1(10, 239, 2); exp1(11, 239, 3);
    run(1'b0, 0, 2, 1);
    chk("clipy_vga_hold", 32'({vx1, vy1, vc1}), 32'({9'd11, 8'd240, 3'd5}));

    // Colour 0 at (11,20): keyed out only with the transparency build
    sprite1(10, 20, 1, 0, 3, 4);
    exp1(10, 20, 1);
`ifdef SPRITE_TRANSPARENCY_EN
    exp_t = 3;
`else
    exp1(11, 20, 0);
    exp_t = 4;
`endif
    exp1(10, 21, 3); exp1(11, 21, 4);
    run(1'b0, 0, exp_t, 1);

    // Second start two cycles into DRAW is ignored
    sprite1(10, 20, 1, 2, 3, 4);
    exp1(10, 20, 1); exp1(11, 20, 2); exp1(10, 21, 3); exp1(11, 21, 4);
    run(1'b0, 4, 4, 1);

    // ROM latency 3: colours stay aligned, longer flush
    exp3(10, 20, 5); exp3(11, 20, 6); exp3(10, 21, 7); exp3(11, 21, 1);
    run(1'b1, 0, 4, 3);

    // Reset after two plots, then a clean redraw
    sprite1(10, 20, 1, 2, 3, 4);
    exp1(10, 20, 1); exp1(11, 20, 2); exp1(10, 21, 3); exp1(11, 21, 4);
    pc1 = 0; fc1 = 0; first1 = -1;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (pc1 < 2 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("midreset_two_plots_first", 32'(pc1), 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_plot", 32'(plot1), 0);
    chk("midreset_busy", 32'(busy1), 0);
    chk("midreset_draw_enable", 32'(en1), 0);
    chk("midreset_draw_reset_n", 32'(drn1), 0);
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("midreset_no_finished", 32'(fc1), 0);
    chk("midreset_no_more_plots", 32'(pc1), 2);
    exp1(10, 20, 1); exp1(11, 20, 2); exp1(10, 21, 3); exp1(11, 21, 4);
    run(1'b0, 0, 4, 1);

    chk("final_q1_empty", 32'(q1.size()), 0);
    chk("final_q3_empty", 32'(q3.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
